dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DM_ADDRESS, default 9, data memory address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_LIM, default 4, maximum number of cycles a pending debug request waits before a forced grant.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 core_req/core_we  input  1/1  pipeline MEM-stage access request / write (1) or read (0).
REQ-007 core_addr/core_wdata/core_funct3  input  DM_ADDRESS/DATA_W/3  core access fields.
REQ-008 core_stall  output  1  core_req asserted and not granted this cycle; freezes the pipeline.
REQ-009 core_rdata/core_rvalid  output  DATA_W/1  read data returned to the core / valid strobe.
REQ-010 dbg_req/dbg_we/dbg_lock  input  1/1/1  debug-loader request / write / hold bus across accesses.
REQ-011 dbg_addr/dbg_wdata/dbg_funct3  input  DM_ADDRESS/DATA_W/3  debug access fields.
REQ-012 dbg_gnt  output  1  debug access accepted this cycle.
REQ-013 dbg_rdata/dbg_rvalid  output  DATA_W/1  read data returned to debug / valid strobe.
REQ-014 mem_rd/mem_wr/mem_addr/mem_wdata/mem_funct3  output  1/1/DM_ADDRESS/DATA_W/3  shared data-memory port.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_rd.

Function
REQ-016 Exactly one access per cycle; mem_rd/mem_wr and the address/data fields come combinationally from the granted requester; all are 0 with no grant.
REQ-017 Requesters hold req and fields stable until granted; a grant consumes the access in that cycle.
REQ-018 FSM states IDLE, CORE, DBG, DBG_LOCK; the state is the owner of the previous cycle.
REQ-019 Default priority: core over debug when both request.
REQ-020 IDLE/CORE/DBG: grant debug if only dbg_req; grant core if core_req; next state = owner, or IDLE with no grant.
REQ-021 A debug grant with dbg_lock=1 moves to DBG_LOCK; in DBG_LOCK only debug is granted and core_stall=core_req, until a cycle with dbg_lock=0 returns to IDLE.
REQ-022 Reads: an owner tag flop captures the requester of each read; exactly one cycle later mem_rdata is routed to that requester's rdata with a one-cycle rvalid.
REQ-023 core_rdata/dbg_rdata hold their last value when rvalid is low.
REQ-024 Writes produce no rvalid.
REQ-025 Back-to-back reads from alternating requesters return data in grant order, one per cycle.

Reset
REQ-026 During reset: state=IDLE, starvation counter=0, owner tag cleared; all grants, mem_rd, mem_wr, rvalid, core_stall are 0; rdata are 0.
REQ-027 Reset asserted mid-lock or with a read in flight discards the pending response; no rvalid follows reset.

Configuration
REQ-028 Macro DMEM_ARB_STARVE_EN: when defined, an saturating counter increments each cycle dbg_req is pending and ungranted, clears on debug grant, and at STARVE_LIM forces the next grant to debug over core.
REQ-029 Without DMEM_ARB_STARVE_EN, strict core priority; debug may wait indefinitely.

Verification
REQ-030 Core read addr 0x010 alone, mem returns 0xDEADBEEF -> mem_rd=1 cycle N, core_rvalid=1 and core_rdata=0xDEADBEEF cycle N+1, core_stall=0.
REQ-031 Core and debug write simultaneously -> core granted, core_stall=0, dbg_gnt=0; debug granted next cycle once core_req drops.
REQ-032 Debug read with dbg_lock=1 for 3 accesses while core_req=1 -> core_stall=1 for 3 cycles, 3 dbg_rvalid pulses, core granted the cycle after dbg_lock=0.
REQ-033 DMEM_ARB_STARVE_EN, STARVE_LIM=4, core_req and dbg_req held high -> dbg_gnt=1 on 5th cycle, core_stall=1 that cycle; without macro dbg_gnt stays 0.
REQ-034 Alternating core read 0x004 / debug read 0x008 -> rvalid alternates core/debug each cycle with matching data.
REQ-035 Reset asserted cycle after a debug read grant -> dbg_rvalid stays 0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its two requesters plus the shared memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline/loader/memory.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  core_req;
    logic                  core_we;
    logic [DM_ADDRESS-1:0] core_addr;
    logic [DATA_W-1:0]     core_wdata;
    logic [2:0]            core_funct3;
    logic                  core_stall;
    logic [DATA_W-1:0]     core_rdata;
    logic                  core_rvalid;

    logic                  dbg_req;
    logic                  dbg_we;
    logic                  dbg_lock;
    logic [DM_ADDRESS-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_wdata;
    logic [2:0]            dbg_funct3;
    logic                  dbg_gnt;
    logic [DATA_W-1:0]     dbg_rdata;
    logic                  dbg_rvalid;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_funct3,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata, dbg_funct3,
        input  mem_rdata,
        output core_stall, core_rdata, core_rvalid,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_funct3,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata, dbg_funct3,
        output mem_rdata,
        input  core_stall, core_rdata, core_rvalid,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core MEM stage and the debug loader, core first by default.
// Build option DMEM_ARB_STARVE_EN adds a starvation counter that forces a debug grant at STARVE_LIM.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave io_bus
);
    typedef enum logic [1:0] {IDLE, CORE, DBG, DBG_LOCK} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              w_coreGnt;
    logic              w_dbgGnt;
    logic              w_forceDbg;
    logic              r_rdPend;
    logic              r_rdOwnerDbg;
    logic              w_coreRvalid;
    logic              w_dbgRvalid;
    logic [DATA_W-1:0] r_coreRdata;
    logic [DATA_W-1:0] r_dbgRdata;

`ifdef DMEM_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIM + 1);
    logic [CW-1:0] r_starveCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starveCnt <= '0;
        end else if (w_dbgGnt) begin
            r_starveCnt <= '0;
        end else if (io_bus.dbg_req && (r_starveCnt != CW'(STARVE_LIM))) begin
            r_starveCnt <= r_starveCnt + CW'(1);
        end
    end

    assign w_forceDbg = (r_starveCnt == CW'(STARVE_LIM));
`else
    // Strict core priority: the limit can never be reached, so debug is never forced.
    assign w_forceDbg = (STARVE_LIM < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_coreGnt   = 1'b0;
        w_dbgGnt    = 1'b0;
        if (reset) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                DBG_LOCK: begin
                    w_dbgGnt    = io_bus.dbg_req;
                    w_nextState = io_bus.dbg_lock ? DBG_LOCK : IDLE;
                end
                default: begin
                    if (io_bus.dbg_req && (w_forceDbg || !io_bus.core_req)) begin
                        w_dbgGnt    = 1'b1;
                        w_nextState = io_bus.dbg_lock ? DBG_LOCK : DBG;
                    end else if (io_bus.core_req) begin
                        w_coreGnt   = 1'b1;
                        w_nextState = CORE;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            endcase
        end
    end

    assign io_bus.core_stall = io_bus.core_req && !w_coreGnt && !reset;
    assign io_bus.dbg_gnt    = w_dbgGnt;
    assign io_bus.mem_rd     = (w_coreGnt && !io_bus.core_we) || (w_dbgGnt && !io_bus.dbg_we);
    assign io_bus.mem_wr     = (w_coreGnt && io_bus.core_we) || (w_dbgGnt && io_bus.dbg_we);
    assign io_bus.mem_addr   = w_coreGnt ? io_bus.core_addr
                             : (w_dbgGnt ? io_bus.dbg_addr : {DM_ADDRESS{1'b0}});
    assign io_bus.mem_wdata  = w_coreGnt ? io_bus.core_wdata
                             : (w_dbgGnt ? io_bus.dbg_wdata : {DATA_W{1'b0}});
    assign io_bus.mem_funct3 = w_coreGnt ? io_bus.core_funct3
                             : (w_dbgGnt ? io_bus.dbg_funct3 : 3'b000);

    // The owner tag remembers who issued last cycle's read so the returning data goes to them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdPend     <= 1'b0;
            r_rdOwnerDbg <= 1'b0;
        end else begin
            r_rdPend     <= (w_coreGnt && !io_bus.core_we) || (w_dbgGnt && !io_bus.dbg_we);
            r_rdOwnerDbg <= w_dbgGnt;
        end
    end

    assign w_coreRvalid = r_rdPend && !r_rdOwnerDbg && !reset;
    assign w_dbgRvalid  = r_rdPend && r_rdOwnerDbg && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coreRdata <= '0;
            r_dbgRdata  <= '0;
        end else begin
            if (w_coreRvalid) begin
                r_coreRdata <= io_bus.mem_rdata;
            end
            if (w_dbgRvalid) begin
                r_dbgRdata <= io_bus.mem_rdata;
            end
        end
    end

    assign io_bus.core_rvalid = w_coreRvalid;
    assign io_bus.dbg_rvalid  = w_dbgRvalid;
    assign io_bus.core_rdata  = reset ? '0 : (w_coreRvalid ? io_bus.mem_rdata : r_coreRdata);
    assign io_bus.dbg_rdata   = reset ? '0 : (w_dbgRvalid ? io_bus.mem_rdata : r_dbgRdata);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: fixed vector table, lock and starvation sequences, then random traffic
// compared against a grant/response model kept here in the bench.
module tb_dmem_arbiter;
    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LIM = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit StarveOn = 1'b1;
`else
    localparam bit StarveOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          cReq;
        logic          cWe;
        logic [AW-1:0] cAddr;
        logic [DW-1:0] cWdata;
        logic [2:0]    cF3;
        logic          dReq;
        logic          dWe;
        logic          dLock;
        logic [AW-1:0] dAddr;
        logic [DW-1:0] dWdata;
        logic [2:0]    dF3;
        logic [DW-1:0] mRdata;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic [5:0]    ctrl;
        logic [DW-1:0] cRd;
        logic [DW-1:0] dRd;
    } vec_t;

    typedef struct {
        bit toDbg;
        int due;
    } resp_t;

    int            checks = 0;
    int            errors = 0;
    int            cycleNo = 0;
    bit            mLock = 1'b0;
    int            mStarve = 0;
    resp_t         mPend[$];
    logic [DW-1:0] mCoreHold = '0;
    logic [DW-1:0] mDbgHold = '0;
    logic [5:0]    obsCtrl;
    bit            expGc;
    bit            expGd;
    vec_t          tbl[12];

    function automatic stim_t mk(bit rst, bit cReq, bit cWe, logic [AW-1:0] cA,
                                 bit dReq, bit dWe, bit dLock, logic [AW-1:0] dA,
                                 logic [DW-1:0] mR);
        stim_t t;
        t.rst    = rst;
        t.cReq   = cReq;
        t.cWe    = cWe;
        t.cAddr  = cA;
        t.cWdata = 32'hC0DE_0000 ^ 32'(cA);
        t.cF3    = 3'd2;
        t.dReq   = dReq;
        t.dWe    = dWe;
        t.dLock  = dLock;
        t.dAddr  = dA;
        t.dWdata = 32'hDB60_0000 ^ 32'(dA);
        t.dF3    = 3'd4;
        t.mRdata = mR;
        return t;
    endfunction

    task automatic applyStimulus(input stim_t s);
        reset           = s.rst;
        bus.core_req    = s.cReq;
        bus.core_we     = s.cWe;
        bus.core_addr   = s.cAddr;
        bus.core_wdata  = s.cWdata;
        bus.core_funct3 = s.cF3;
        bus.dbg_req     = s.dReq;
        bus.dbg_we      = s.dWe;
        bus.dbg_lock    = s.dLock;
        bus.dbg_addr    = s.dAddr;
        bus.dbg_wdata   = s.dWdata;
        bus.dbg_funct3  = s.dF3;
        bus.mem_rdata   = s.mRdata;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides grants from the priority rules and returns read data a cycle later.
    task automatic runCycle(input stim_t s, input string tag);
        logic [5:0]  eCtrl;
        logic [43:0] eBus;
        bit          gC, gD, forced, cRv, dRv;
        resp_t       r;
        @(negedge clk);
        applyStimulus(s);
        #1;
        gC = 1'b0; gD = 1'b0; cRv = 1'b0; dRv = 1'b0; eBus = '0;
        if (s.rst) begin
            mLock = 1'b0;
            mStarve = 0;
            mPend.delete();
            mCoreHold = '0;
            mDbgHold = '0;
        end else begin
            forced = StarveOn && (mStarve >= LIM);
            if (mLock) gD = s.dReq;
            else if (s.dReq && (!s.cReq || forced)) gD = 1'b1;
            else gC = s.cReq;
            if (mPend.size() > 0 && mPend[0].due == cycleNo) begin
                r = mPend.pop_front();
                if (r.toDbg) begin dRv = 1'b1; mDbgHold = s.mRdata; end
                else begin cRv = 1'b1; mCoreHold = s.mRdata; end
            end
            if (gC) eBus = {s.cAddr, s.cWdata, s.cF3};
            else if (gD) eBus = {s.dAddr, s.dWdata, s.dF3};
            if (gC && !s.cWe) mPend.push_back('{toDbg: 1'b0, due: cycleNo + 1});
            if (gD && !s.dWe) mPend.push_back('{toDbg: 1'b1, due: cycleNo + 1});
            mLock = mLock ? bit'(s.dLock) : (gD && s.dLock);
            if (gD) mStarve = 0;
            else if (s.dReq && mStarve < LIM) mStarve++;
        end
        eCtrl = {s.cReq && !gC && !s.rst, gD, (gC && !s.cWe) || (gD && !s.dWe),
                 (gC && s.cWe) || (gD && s.dWe), cRv, dRv};
        obsCtrl = {bus.core_stall, bus.dbg_gnt, bus.mem_rd, bus.mem_wr, bus.core_rvalid, bus.dbg_rvalid};
        checkOutput({tag, " ctrl"}, 64'(obsCtrl), 64'(eCtrl));
        checkOutput({tag, " membus"}, 64'({bus.mem_addr, bus.mem_wdata, bus.mem_funct3}), 64'(eBus));
        checkOutput({tag, " core_rdata"}, 64'(bus.core_rdata), 64'(mCoreHold));
        checkOutput({tag, " dbg_rdata"}, 64'(bus.dbg_rdata), 64'(mDbgHold));
        expGc = gC;
        expGd = gD;
        cycleNo++;
    endtask

    initial begin
        stim_t s;
        stim_t cur;
        bit    cPend, dPend;
        int    stalls, dRvs, firstGnt, stallAtGnt;

        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        runCycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "reset0");
        runCycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "reset1");

        // ctrl = {core_stall, dbg_gnt, mem_rd, mem_wr, core_rvalid, dbg_rvalid}
        tbl[0]  = '{mk(1, 1, 0, 9'h010, 1, 0, 0, 9'h008, 32'h0),         6'b000000, 32'h0,        32'h0};
        tbl[1]  = '{mk(0, 1, 0, 9'h010, 0, 0, 0, 9'h000, 32'h0),         6'b001000, 32'h0,        32'h0};
        tbl[2]  = '{mk(0, 0, 0, 9'h000, 0, 0, 0, 9'h000, 32'hDEADBEEF),  6'b000010, 32'hDEADBEEF, 32'h0};
        tbl[3]  = '{mk(0, 1, 1, 9'h020, 1, 1, 0, 9'h030, 32'h11111111),  6'b000100, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{mk(0, 0, 0, 9'h000, 1, 1, 0, 9'h030, 32'h22222222),  6'b010100, 32'hDEADBEEF, 32'h0};
        tbl[5]  = '{mk(0, 1, 0, 9'h004, 0, 0, 0, 9'h000, 32'h33333333),  6'b001000, 32'hDEADBEEF, 32'h0};
        tbl[6]  = '{mk(0, 0, 0, 9'h000, 1, 0, 0, 9'h008, 32'hA1A1A1A1),  6'b011010, 32'hA1A1A1A1, 32'h0};
        tbl[7]  = '{mk(0, 1, 0, 9'h004, 0, 0, 0, 9'h000, 32'hB2B2B2B2),  6'b001001, 32'hA1A1A1A1, 32'hB2B2B2B2};
        tbl[8]  = '{mk(0, 0, 0, 9'h000, 1, 0, 0, 9'h008, 32'hC3C3C3C3),  6'b011010, 32'hC3C3C3C3, 32'hB2B2B2B2};
        tbl[9]  = '{mk(0, 0, 0, 9'h000, 1, 0, 0, 9'h008, 32'hD4D4D4D4),  6'b011001, 32'hC3C3C3C3, 32'hD4D4D4D4};
        tbl[10] = '{mk(1, 0, 0, 9'h000, 1, 0, 0, 9'h008, 32'hE5E5E5E5),  6'b000000, 32'h0,        32'h0};
        tbl[11] = '{mk(0, 0, 0, 9'h000, 0, 0, 0, 9'h000, 32'hF6F6F6F6),  6'b000000, 32'h0,        32'h0};

        for (int i = 0; i < 12; i++) begin
            runCycle(tbl[i].s, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d table ctrl", i), 64'(obsCtrl), 64'(tbl[i].ctrl));
            checkOutput($sformatf("vec%0d table core_rdata", i), 64'(bus.core_rdata), 64'(tbl[i].cRd));
            checkOutput($sformatf("vec%0d table dbg_rdata", i), 64'(bus.dbg_rdata), 64'(tbl[i].dRd));
        end

        // Locked debug burst while the core waits: three stalls, three debug responses.
        runCycle(mk(0, 0, 0, 0, 1, 1, 1, 9'h050, 32'h0), "lockOpen");
        stalls = 0;
        dRvs = 0;
        for (int i = 0; i < 3; i++) begin
            runCycle(mk(0, 1, 0, 9'h040, 1, 0, (i < 2), 9'(9'h051 + i), 32'h4C00_0000 + i), "lockRead");
            stalls += int'(obsCtrl[5]);
            dRvs += int'(obsCtrl[0]);
        end
        runCycle(mk(0, 1, 0, 9'h040, 0, 0, 0, 0, 32'h4D00_0000), "lockRelease");
        dRvs += int'(obsCtrl[0]);
        checkOutput("lock core granted after release", 64'({obsCtrl[5], obsCtrl[4], obsCtrl[3]}), 64'(3'b001));
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h4E00_0000), "lockFlush");
        checkOutput("lock stall cycles", 64'(stalls), 64'(3));
        checkOutput("lock dbg rvalid pulses", 64'(dRvs), 64'(3));

        // Both requesters held: debug only gets through when starvation control is built in.
        firstGnt = 0;
        stallAtGnt = 0;
        for (int i = 1; i <= 6; i++) begin
            runCycle(mk(0, 1, 0, 9'h060, 1, 0, 0, 9'h070, 32'h5E00_0000 + i), "starve");
            if (obsCtrl[4] && firstGnt == 0) begin
                firstGnt = i;
                stallAtGnt = int'(obsCtrl[5]);
            end
        end
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h5F00_0000), "starveFlush");
        checkOutput("starve first dbg grant cycle", 64'(firstGnt), StarveOn ? 64'(5) : 64'(0));
        checkOutput("starve core_stall at dbg grant", 64'(stallAtGnt), 64'(StarveOn));

        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cPend = 1'b0;
        dPend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            s = cur;
            s.rst = ($urandom_range(0, 49) == 0);
            s.mRdata = $urandom;
            if (!cPend) begin
                s.cReq = ($urandom_range(0, 1) == 1);
                s.cWe = ($urandom_range(0, 1) == 1);
                s.cAddr = 9'($urandom);
                s.cWdata = $urandom;
                s.cF3 = 3'($urandom);
            end
            if (!dPend) begin
                s.dReq = ($urandom_range(0, 2) == 0);
                s.dWe = ($urandom_range(0, 1) == 1);
                s.dLock = ($urandom_range(0, 3) == 0);
                s.dAddr = 9'($urandom);
                s.dWdata = $urandom;
                s.dF3 = 3'($urandom);
            end
            runCycle(s, "rand");
            cPend = s.cReq && !expGc;
            dPend = s.dReq && !expGd;
            cur = s;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
